// File: rtl/uart_loader_if.sv
// Byte-stream input and instruction-memory write/status bundle for uart_loader.
interface uart_loader_if #(
  parameter int unsigned AddrWidth = 8
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 mem_we;
  logic [AddrWidth-1:0] mem_addr;
  logic [31:0]          mem_wdata;
  logic                 cpu_hold;
  logic                 load_done;
  logic                 load_error;

  // Loader side: consumes received bytes, drives memory writes and status.
  modport master (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
  );

  // Environment side: UART receiver feeding bytes, memory/CPU observing.
  modport slave (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/uart_loader.sv
// Boot loader: parses A5/len/words/checksum frames from the UART byte stream
// into instruction-memory word writes, holding the CPU in reset while loading.
module uart_loader #(
  parameter int unsigned AddrWidth     = 8,
  parameter logic [7:0]  HeaderByte    = 8'hA5,
  parameter int unsigned TimeoutCycles = 1_000_000
) (
  input  logic           clk,
  input  logic           rst,
  uart_loader_if.master  bus
);

  localparam int unsigned TimeoutW = $clog2(TimeoutCycles) + 1;
  localparam int unsigned MaxWords = 2 ** AddrWidth;
  // The abort fires on the edge where the idle count would reach TimeoutCycles-1.
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TimeoutCycles - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           word_idx_q, word_idx_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [31:0]          word_q, word_d;
  logic [7:0]           checksum_q, checksum_d;
  logic [TimeoutW-1:0]  tmo_q, tmo_d;
  logic                 mem_we_q, mem_we_d;
  logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic                 cpu_hold_q, cpu_hold_d;
  logic                 load_done_q, load_done_d;
  logic                 load_error_q, load_error_d;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      checksum_q   <= '0;
      tmo_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      checksum_q   <= checksum_d;
      tmo_q        <= tmo_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  // Frame parser: next state, datapath and registered output values.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    checksum_d   = checksum_q;
    tmo_d        = '0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.rx_valid && (bus.rx_data == HeaderByte)) begin
          state_d      = S_LEN;
          cpu_hold_d   = 1'b1;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
          checksum_d   = '0;
          word_idx_d   = '0;
          byte_idx_d   = '0;
        end
      end
      S_LEN: begin
        if (bus.rx_valid) begin
          len_d = bus.rx_data;
          if ((bus.rx_data == 8'd0) || (32'(bus.rx_data) > 32'(MaxWords))) begin
            state_d      = S_ERROR;
            load_error_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (bus.rx_valid) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = bus.rx_data;
          checksum_d = checksum_q + bus.rx_data;
          if (byte_idx_q == 2'd3) begin
            state_d     = S_WRITE;
            byte_idx_d  = '0;
            mem_we_d    = 1'b1;
            mem_addr_d  = AddrWidth'(word_idx_q);
            mem_wdata_d = word_d;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        if (bus.rx_valid) begin
          state_d      = S_ERROR;
          load_error_d = 1'b1;
        end else if (word_idx_q == (len_q - 8'd1)) begin
          state_d = S_CHECK;
        end else begin
          word_idx_d = word_idx_q + 8'd1;
          state_d    = S_DATA;
        end
      end
      S_CHECK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == checksum_q) begin
            state_d     = S_DONE;
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            state_d      = S_ERROR;
            load_error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte watchdog, active only while waiting for frame bytes.
    if (((state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHECK)) && !bus.rx_valid) begin
      if (tmo_q == TimeoutLast) begin
        state_d      = S_ERROR;
        load_error_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.load_done  = load_done_q;
  assign bus.load_error = load_error_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: directed and random frames, write scoreboard and status checks.
module tb_uart_loader;
  localparam int unsigned AW = 8;
  localparam int unsigned TO = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_loader_if #(.AddrWidth(AW)) bus ();

  uart_loader #(.AddrWidth(AW), .HeaderByte(8'hA5), .TimeoutCycles(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  wr_t mon_e;
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h at %0t", bus.mem_addr, bus.mem_wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
        check("wr_data", bus.mem_wdata, mon_e.data);
      end
    end
  end

  // Reference model: queues the writes a frame should produce, returns whether it ends good.
  task automatic expect_frame(input logic [7:0] fr[$], output logic ok);
    int unsigned n;
    logic [7:0]  sum;
    wr_t         e;
    n   = fr[0];
    sum = 8'd0;
    if (n == 0 || n > (1 << AW)) begin
      ok = 1'b0;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      e.addr = AW'(i);
      e.data = {fr[4*i+4], fr[4*i+3], fr[4*i+2], fr[4*i+1]};
      exp_q.push_back(e);
      for (int j = 1; j <= 4; j++) sum = sum + fr[4*i+j];
    end
    ok = (fr[4*n+1] == sum);
  endtask

  function automatic logic [7:0] csum(input logic [7:0] d[$]);
    logic [7:0] s = 8'd0;
    foreach (d[i]) s = s + d[i];
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic check_status(input string tag, input logic done, input logic err, input logic hold);
    check({tag, "_done"}, 32'(bus.load_done), 32'(done));
    check({tag, "_error"}, 32'(bus.load_error), 32'(err));
    check({tag, "_hold"}, 32'(bus.cpu_hold), 32'(hold));
  endtask

  // Sends header + frame body; last byte has no gap so status is sampled one cycle after it.
  task automatic run_frame(input string tag, input logic [7:0] fr[$]);
    logic ok;
    expect_frame(fr, ok);
    send_byte(8'hA5, 1);
    check({tag, "_hold_after_hdr"}, 32'(bus.cpu_hold), 32'd1);
    for (int i = 0; i < fr.size(); i++) begin
      if (i == fr.size() - 1) begin
        if (i > 0) check({tag, "_hold_before_last"}, 32'(bus.cpu_hold), 32'd1);
        send_byte(fr[i], 0);
      end else begin
        send_byte(fr[i], $urandom_range(1, 3));
      end
    end
    if (ok) check_status(tag, 1'b1, 1'b0, 1'b0);
    else    check_status(tag, 1'b0, 1'b1, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    logic [7:0] d[$];
    logic [7:0] b;
    logic [7:0] s;
    int         first;
    int unsigned n;
    wr_t        e;

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0);

    // Noise before a header is ignored; zero-length frame aborts without writes.
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_byte(8'h13, 1);
    check_status("noise", 1'b0, 1'b0, 1'b0);
    fr = '{8'h00};
    run_frame("zero_len", fr);

    // Two-word good frame, then bad checksum, then recovery.
    d  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    s  = csum(d);
    fr = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    fr.push_back(s);
    run_frame("good", fr);
    fr[9] = 8'h7D;
    run_frame("bad_sum", fr);
    fr[9] = s;
    run_frame("recover", fr);

    // Stall mid-word: abort lands exactly TO-1 cycles after the last strobe.
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 0);
    first = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (bus.load_error === 1'b1 && first == 0) first = k;
    end
    check("timeout_latency", 32'(first), 32'(TO - 1));
    check_status("timeout", 1'b0, 1'b1, 1'b1);

    // Reset mid-load after one word was written.
    e.addr = '0;
    e.data = 32'h04030201;
    exp_q.push_back(e);
    send_byte(8'hA5, 1);
    send_byte(8'h03, 1);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    send_byte(8'h03, 1);
    send_byte(8'h04, 1);
    send_byte(8'h09, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    check("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("midrst_mem_wdata", bus.mem_wdata, 32'd0);
    check_status("midrst", 1'b0, 1'b0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    fr = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    run_frame("after_rst", fr);

    // Byte arriving during the write cycle: word still written, then abort.
    e.addr = '0;
    e.data = 32'h44332211;
    exp_q.push_back(e);
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    send_byte(8'h33, 1);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    check_status("collision", 1'b0, 1'b1, 1'b1);
    repeat (3) begin @(posedge clk); #1; end

    // Random frames with inter-frame noise and occasional corrupted checksums.
    for (int f = 0; f < 20; f++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      send_byte(b, 1);
      n = $urandom_range(1, 4);
      fr.delete();
      fr.push_back(8'(n));
      s = 8'd0;
      for (int i = 0; i < int'(4 * n); i++) begin
        b = ($urandom_range(0, 9) == 0) ? 8'hA5 : 8'($urandom);
        fr.push_back(b);
        s = s + b;
      end
      if ($urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
      fr.push_back(s);
      run_frame("rand", fr);
    end

    repeat (5) begin @(posedge clk); #1; end
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
